// File: rtl/instruction_fetch_unit.sv
// Single-issue, non-pipelined fetch sequencer: owns the PC, fetches over req/ack, resolves redirects.
// Optional fetch watchdog with sticky ERROR state is enabled by defining IFU_WATCHDOG_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_error
);

`ifdef IFU_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERROR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
`endif

  state_t      state, state_nx;
  logic [31:0] next_pc;
  logic        taken;

  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;
  assign op          = instr[31:26];
  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == ISSUE);

`ifdef IFU_WATCHDOG_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wait_cnt;
  logic          timeout;

  // Counter sits at zero outside FETCH, so it is already cleared on entry.
  assign timeout     = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign fetch_error = (state == ERROR);

  always_ff @(posedge clk) begin
    if (reset || state != FETCH)
      wait_cnt <= '0;
    else if (!imem_ack && !timeout)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign fetch_error = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (imem_ack)
          state_nx = ISSUE;
`ifdef IFU_WATCHDOG_EN
        else if (timeout)
          state_nx = ERROR;
`endif
      end
      ISSUE: if (exec_done) state_nx = FETCH;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    taken = (branch_eq & zero) | (branch_ne & ~zero);
    if (jr)
      next_pc = {jr_target[31:2], 2'b00};
    else if (jump | jal)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken)
      next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    else
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_ack)
        instr <= imem_rdata;
      if (state == ISSUE && exec_done)
        pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit against a next-PC reference model.
// Watchdog checks follow IFU_WATCHDOG_EN when it is defined for the build.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_eq, branch_ne, zero, jump, jal, jr;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_error;

  int unsigned vectors = 0;
  int unsigned errs    = 0;
  logic [31:0] m_pc;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .instr_valid(instr_valid), .exec_done(exec_done),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
    .jump(jump), .jal(jal), .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule, computed with plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic beq, input logic bne, input logic z,
                                           input logic jmp, input logic jl, input logic jrr,
                                           input logic [31:0] jt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jrr) return jt - (jt % 4);
    if (jmp || jl) return (seq & 32'hF000_0000) + ({6'd0, ins[25:0]} * 32'd4);
    if ((beq && z) || (bne && !z)) begin
      off = int'($signed(ins[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Entered with the DUT in its first FETCH cycle; leaves it in the first FETCH cycle of the next PC.
  task automatic txn(input logic [31:0] rdata, input int unsigned ack_dly, input int unsigned issue_dly,
                     input logic beq, input logic bne, input logic z,
                     input logic jmp, input logic jl, input logic jrr, input logic [31:0] jt);
    logic [31:0] nxt;
    chk(imem_req, 1, "req_in_fetch");
    chk(imem_addr, m_pc, "fetch_addr");
    chk(instr_valid, 0, "valid_low_in_fetch");
    chk(fetch_error, 0, "no_error");
    for (int unsigned k = 0; k < ack_dly; k++) begin
      exec_done  = 1'($urandom);
      imem_rdata = $urandom;
      step();
      chk(imem_req, 1, "req_held_waiting");
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ack = 1'b0;
    chk(instr_valid, 1, "valid_after_ack");
    chk(imem_req, 0, "req_low_in_issue");
    chk(instr, rdata, "instr_latched");
    chk(op, rdata[31:26], "op_field");
    chk(pc, m_pc, "pc_in_issue");
    chk(pc_plus4, m_pc + 32'd4, "pc_plus4");
    for (int unsigned k = 0; k < issue_dly; k++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      step();
      chk(instr, rdata, "instr_stable_in_issue");
      chk(instr_valid, 1, "valid_held");
    end
    imem_ack = 1'b0;
    branch_eq = beq; branch_ne = bne; zero = z;
    jump = jmp; jal = jl; jr = jrr; jr_target = jt;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    branch_eq = 0; branch_ne = 0; zero = 0; jump = 0; jal = 0; jr = 0; jr_target = $urandom;
    nxt  = ref_next(m_pc, rdata, beq, bne, z, jmp, jl, jrr, jt);
    m_pc = nxt;
    chk(imem_req, 1, "req_after_done");
    chk(imem_addr, nxt, "next_pc");
    chk(instr_valid, 0, "valid_low_after_done");
  endtask

  initial begin
    logic        rb, rbe, rbn, rz, rj, rjl, rjr;
    logic [31:0] rw;

    reset = 1'b1; imem_ack = 0; imem_rdata = '0; exec_done = 0;
    branch_eq = 0; branch_ne = 0; zero = 0; jump = 0; jal = 0; jr = 0; jr_target = '0;
    step(); step();
    chk(imem_req, 0, "rst_req");
    chk(instr_valid, 0, "rst_valid");
    chk(instr, 0, "rst_instr");
    chk(pc, RST_PC, "rst_pc");
    chk(fetch_error, 0, "rst_error");
    reset = 1'b0;
    step();
    m_pc = RST_PC;

    // Directed cases
    txn(32'h2008_0005, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0);                 // addi, falls through to +4
    txn($urandom, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0010);              // jr to set up branch pc
    txn(32'h1000_FFFF, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0);                 // beq taken, offset -1
    chk(m_pc, 32'h0040_0010, "beq_taken_target");
    txn(32'h1000_FFFF, 2, 0, 1, 0, 0, 0, 0, 0, 32'h0);                 // beq not taken
    chk(imem_addr, 32'h0040_0014, "beq_not_taken_addr");
    txn($urandom, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0000);
    txn(32'h0C10_0008, 0, 2, 0, 0, 0, 0, 1, 0, 32'h0);                 // jal
    chk(imem_addr, 32'h0040_0020, "jal_target");
    txn($urandom, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0040_0103);              // jr beats jump
    chk(imem_addr, 32'h0040_0100, "jr_priority");
    txn(32'h0800_0004, 0, 0, 1, 1, 1, 1, 0, 0, 32'h0);                 // jump beats branch
    txn($urandom, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    txn($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);                      // 0xFFFF_FFFC + 4 wraps
    chk(imem_addr, 32'h0000_0000, "pc_wrap");

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      rw  = $urandom;
      rbe = ($urandom_range(0, 2) == 0);
      rbn = ($urandom_range(0, 2) == 0);
      rz  = 1'($urandom);
      rj  = ($urandom_range(0, 4) == 0);
      rjl = ($urandom_range(0, 4) == 0);
      rjr = ($urandom_range(0, 4) == 0);
      txn(rw, $urandom_range(0, 3), $urandom_range(0, 2), rbe, rbn, rz, rj, rjl, rjr, $urandom);
    end

    // Reset while FETCH waits; an ack during the following IDLE cycle must be ignored
    step(); step();
    reset = 1'b1;
    step();
    chk(imem_req, 0, "reset_mid_fetch_req");
    chk(pc, RST_PC, "reset_mid_fetch_pc");
    chk(instr, 0, "reset_mid_fetch_instr");
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk(imem_req, 1, "refetch_req");
    chk(imem_addr, RST_PC, "refetch_addr");
    chk(instr, 0, "late_ack_ignored");
    m_pc = RST_PC;
    txn(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Ack on the last permitted wait cycle is a normal capture in either build
    txn($urandom, 15, 0, 0, 0, 0, 0, 0, 0, 32'h0);

`ifdef IFU_WATCHDOG_EN
    repeat (15) step();
    chk(imem_req, 1, "wd_req_before_limit");
    chk(fetch_error, 0, "wd_no_error_before_limit");
    step();
    chk(fetch_error, 1, "wd_error_at_limit");
    chk(imem_req, 0, "wd_req_dropped");
    chk(instr_valid, 0, "wd_valid_low");
    imem_ack = 1'b1; exec_done = 1'b1;
    repeat (4) step();
    imem_ack = 1'b0; exec_done = 1'b0;
    chk(fetch_error, 1, "wd_error_sticky");
    chk(imem_req, 0, "wd_req_stays_low");
    reset = 1'b1;
    step();
    chk(fetch_error, 0, "wd_error_cleared");
    reset = 1'b0;
    step();
    m_pc = RST_PC;
`else
    repeat (40) step();
    chk(imem_req, 1, "no_wd_req_held");
    chk(fetch_error, 0, "no_wd_error_tied");
`endif
    txn(32'h2008_0005, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
